// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin system bus arbiter: FSM encodings,
// master-count bound and index width.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int MAX_MASTERS  = 8;
    localparam int MASTER_IDX_W = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at pointer, pointer+1, ...
// wrapping modulo NUM_MASTERS.
module bus_arbiter_rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0]  requests,
    input  logic [MASTER_IDX_W-1:0] pointer,
    output logic                    valid,
    output logic [MASTER_IDX_W-1:0] index
);

    // Scan from the farthest offset down so the nearest request overrides.
    always_comb begin
        valid = |requests;
        index = pointer;
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            index = requests[(int'(pointer) + off) % NUM_MASTERS]
                  ? MASTER_IDX_W'((int'(pointer) + off) % NUM_MASTERS)
                  : index;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter: grant held from grant through end of
// transaction, with begin and transfer watchdogs.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS   = 4,
    parameter int BEGIN_TIMEOUT = 16,
    parameter int XFER_TIMEOUT  = 1024
) (
    input  logic                    clock,
    input  logic                    n_reset,
    input  logic [NUM_MASTERS-1:0]  requestTransaction,
    output logic [NUM_MASTERS-1:0]  transactionGranted,
    input  logic                    begin_transactionIN,
    input  logic                    end_transactionIN,
    input  logic                    bus_errorIN,
    output logic                    end_transactionOUT,
    output logic                    bus_owned,
    output logic [MASTER_IDX_W-1:0] active_master,
    output logic                    begin_timeout,
    output logic                    xfer_timeout,
    output logic                    error_seen
);

    localparam int CNT_MAX = max_int(BEGIN_TIMEOUT, XFER_TIMEOUT);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [NUM_MASTERS-1:0] LSB_ONLY = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    arb_state_t              state_r, state_next;
    logic [CNT_W-1:0]        counter_r, counter_next;
    logic [MASTER_IDX_W-1:0] rr_pointer_r, rr_pointer_next;
    logic [MASTER_IDX_W-1:0] active_r, active_next;
    logic [NUM_MASTERS-1:0]  grant_r, grant_next;
    logic                    owned_r, owned_next;
    logic                    end_out_r, end_out_next;
    logic                    begin_to_r, begin_to_next;
    logic                    xfer_to_r, xfer_to_next;
    logic                    error_r, error_next;
    logic                    pick_valid;
    logic [MASTER_IDX_W-1:0] pick_index;

    bus_arbiter_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .requests (requestTransaction),
        .pointer  (rr_pointer_r),
        .valid    (pick_valid),
        .index    (pick_index)
    );

    // Next-state, counter and next-output computation.
    always_comb begin
        state_next      = state_r;
        counter_next    = counter_r;
        rr_pointer_next = rr_pointer_r;
        active_next     = active_r;
        grant_next      = grant_r;
        end_out_next    = 1'b0;
        begin_to_next   = 1'b0;
        xfer_to_next    = 1'b0;
        error_next      = error_r;
        case (state_r)
            IDLE: begin
                if (pick_valid) begin
                    state_next   = GRANT;
                    counter_next = '0;
                    grant_next   = LSB_ONLY << pick_index;
                    active_next  = pick_index;
                end else begin
                    grant_next   = '0;
                end
            end
            GRANT: begin
                if (begin_transactionIN) begin
                    state_next   = BUSY;
                    counter_next = '0;
                end else if (counter_r == CNT_W'(BEGIN_TIMEOUT - 1)) begin
                    state_next    = RELEASE;
                    counter_next  = '0;
                    grant_next    = '0;
                    begin_to_next = 1'b1;
                end else begin
                    counter_next  = counter_r + CNT_W'(1);
                end
            end
            BUSY: begin
                // An error is only recorded; ownership still ends on end or timeout.
                error_next = error_r | bus_errorIN;
                if (end_transactionIN) begin
                    state_next   = RELEASE;
                    counter_next = '0;
                    grant_next   = '0;
                end else if (counter_r == CNT_W'(XFER_TIMEOUT - 1)) begin
                    state_next   = RELEASE;
                    counter_next = '0;
                    grant_next   = '0;
                    end_out_next = 1'b1;
                    xfer_to_next = 1'b1;
                end else begin
                    counter_next = counter_r + CNT_W'(1);
                end
            end
            RELEASE: begin
                state_next      = IDLE;
                counter_next    = '0;
                grant_next      = '0;
                rr_pointer_next = (active_r == MASTER_IDX_W'(NUM_MASTERS - 1))
                                ? '0 : active_r + MASTER_IDX_W'(1);
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
                grant_next   = '0;
            end
        endcase
        owned_next = (state_next == GRANT) || (state_next == BUSY);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_r      <= IDLE;
            counter_r    <= '0;
            rr_pointer_r <= '0;
            active_r     <= '0;
            grant_r      <= '0;
            owned_r      <= 1'b0;
            end_out_r    <= 1'b0;
            begin_to_r   <= 1'b0;
            xfer_to_r    <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_next;
            counter_r    <= counter_next;
            rr_pointer_r <= rr_pointer_next;
            active_r     <= active_next;
            grant_r      <= grant_next;
            owned_r      <= owned_next;
            end_out_r    <= end_out_next;
            begin_to_r   <= begin_to_next;
            xfer_to_r    <= xfer_to_next;
            error_r      <= error_next;
        end
    end

    assign transactionGranted = grant_r;
    assign bus_owned          = owned_r;
    assign active_master      = active_r;
    assign end_transactionOUT = end_out_r;
    assign begin_timeout      = begin_to_r;
    assign xfer_timeout       = xfer_to_r;
    assign error_seen         = error_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with hand-computed expectations.
module tb_bus_arbiter;

    logic       clock;
    logic       n_reset;
    logic [3:0] requestTransaction;
    logic [3:0] transactionGranted;
    logic       begin_transactionIN;
    logic       end_transactionIN;
    logic       bus_errorIN;
    logic       end_transactionOUT;
    logic       bus_owned;
    logic [2:0] active_master;
    logic       begin_timeout;
    logic       xfer_timeout;
    logic       error_seen;

    int assertions_evaluated = 0;
    int failures = 0;

    bus_arbiter #(
        .NUM_MASTERS   (4),
        .BEGIN_TIMEOUT (16),
        .XFER_TIMEOUT  (1024)
    ) dut (
        .clock               (clock),
        .n_reset             (n_reset),
        .requestTransaction  (requestTransaction),
        .transactionGranted  (transactionGranted),
        .begin_transactionIN (begin_transactionIN),
        .end_transactionIN   (end_transactionIN),
        .bus_errorIN         (bus_errorIN),
        .end_transactionOUT  (end_transactionOUT),
        .bus_owned           (bus_owned),
        .active_master       (active_master),
        .begin_timeout       (begin_timeout),
        .xfer_timeout        (xfer_timeout),
        .error_seen          (error_seen)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions_evaluated++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_reset             = 1'b0;
        requestTransaction  = 4'b0000;
        begin_transactionIN = 1'b0;
        end_transactionIN   = 1'b0;
        bus_errorIN         = 1'b0;
        tick();
        tick();
        check_value("rst_grant", 32'(transactionGranted), 32'h0);
        check_value("rst_owned", 32'(bus_owned), 32'h0);
        check_value("rst_active", 32'(active_master), 32'h0);
        check_value("rst_error", 32'(error_seen), 32'h0);
        check_value("rst_pulses", 32'({end_transactionOUT, begin_timeout, xfer_timeout}), 32'h0);
        n_reset = 1'b1;

        // Single master 0: grant, drop request, begin, 10-cycle transfer.
        requestTransaction = 4'b0001;
        tick();
        check_value("t1_grant", 32'(transactionGranted), 32'h1);
        check_value("t1_owned", 32'(bus_owned), 32'h1);
        requestTransaction = 4'b0000;
        tick();
        begin_transactionIN = 1'b1;
        tick();
        begin_transactionIN = 1'b0;
        repeat (9) tick();
        check_value("t1_busy_grant", 32'(transactionGranted), 32'h1);
        end_transactionIN = 1'b1;
        tick();
        end_transactionIN = 1'b0;
        check_value("t1_rel_grant", 32'(transactionGranted), 32'h0);
        check_value("t1_rel_owned", 32'(bus_owned), 32'h0);
        check_value("t1_no_pulses", 32'({end_transactionOUT, begin_timeout, xfer_timeout}), 32'h0);
        requestTransaction = 4'b0001;
        tick();
        check_value("t1_idle_gap", 32'(transactionGranted), 32'h0);
        tick();
        check_value("t1_regrant", 32'(transactionGranted), 32'h1);
        requestTransaction  = 4'b0000;
        begin_transactionIN = 1'b1;
        tick();
        begin_transactionIN = 1'b0;
        end_transactionIN   = 1'b1;
        tick();
        end_transactionIN   = 1'b0;
        tick();

        // Masters 0,1,2 requesting continuously from a fresh pointer.
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        requestTransaction = 4'b0111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_value("t2_grant", 32'(transactionGranted), 32'(4'b0001 << (k % 3)));
            check_value("t2_active", 32'(active_master), 32'(k % 3));
            begin_transactionIN = 1'b1;
            tick();
            begin_transactionIN = 1'b0;
            repeat (3) tick();
            end_transactionIN = 1'b1;
            tick();
            end_transactionIN = 1'b0;
            check_value("t2_dead_cycle", 32'(transactionGranted), 32'h0);
            tick();
        end
        requestTransaction = 4'b0000;

        // Master 3 never begins: revoked 16 cycles after grant.
        requestTransaction = 4'b1000;
        tick();
        check_value("t3_grant", 32'(transactionGranted), 32'h8);
        requestTransaction = 4'b0000;
        repeat (15) tick();
        check_value("t3_pre_timeout", 32'({begin_timeout, bus_owned}), 32'h1);
        tick();
        check_value("t3_begin_timeout", 32'(begin_timeout), 32'h1);
        check_value("t3_grant_dropped", 32'(transactionGranted), 32'h0);
        requestTransaction = 4'b1001;
        tick();
        check_value("t3_pulse_done", 32'(begin_timeout), 32'h0);
        tick();
        check_value("t3_next_grant", 32'(transactionGranted), 32'h1);
        requestTransaction  = 4'b0000;
        begin_transactionIN = 1'b1;
        tick();
        begin_transactionIN = 1'b0;

        // Transfer with no end: forced end after 1024 BUSY cycles.
        repeat (1023) tick();
        check_value("t4_pre_force", 32'({end_transactionOUT, xfer_timeout, bus_owned}), 32'h1);
        tick();
        check_value("t4_end_out", 32'(end_transactionOUT), 32'h1);
        check_value("t4_xfer_timeout", 32'(xfer_timeout), 32'h1);
        check_value("t4_grant_dropped", 32'(transactionGranted), 32'h0);
        tick();
        check_value("t4_pulse_done", 32'({end_transactionOUT, xfer_timeout}), 32'h0);
        check_value("t4_no_error", 32'(error_seen), 32'h0);

        // Bus error mid-transfer on master 1; release only on end.
        requestTransaction = 4'b0010;
        tick();
        check_value("t5_grant", 32'(transactionGranted), 32'h2);
        requestTransaction  = 4'b0000;
        begin_transactionIN = 1'b1;
        tick();
        begin_transactionIN = 1'b0;
        tick();
        bus_errorIN = 1'b1;
        tick();
        bus_errorIN = 1'b0;
        check_value("t5_error_set", 32'(error_seen), 32'h1);
        tick();
        tick();
        check_value("t5_still_held", 32'(transactionGranted), 32'h2);
        end_transactionIN = 1'b1;
        tick();
        end_transactionIN = 1'b0;
        check_value("t5_released", 32'(transactionGranted), 32'h0);
        check_value("t5_no_force", 32'(end_transactionOUT), 32'h0);
        tick();
        check_value("t5_error_sticky", 32'(error_seen), 32'h1);

        // Begin on the timeout cycle, then end on the timeout cycle.
        requestTransaction = 4'b0100;
        tick();
        check_value("t6_grant", 32'(transactionGranted), 32'h4);
        requestTransaction = 4'b0000;
        repeat (15) tick();
        begin_transactionIN = 1'b1;
        tick();
        begin_transactionIN = 1'b0;
        check_value("t6_begin_wins", 32'({begin_timeout, transactionGranted}), 32'h4);
        repeat (1023) tick();
        end_transactionIN = 1'b1;
        tick();
        end_transactionIN = 1'b0;
        check_value("t6_end_wins", 32'({end_transactionOUT, xfer_timeout}), 32'h0);
        check_value("t6_released", 32'(transactionGranted), 32'h0);
        tick();

        // Reset while BUSY with master 3.
        requestTransaction = 4'b1000;
        tick();
        check_value("t7_grant", 32'(transactionGranted), 32'h8);
        check_value("t7_active", 32'(active_master), 32'h3);
        requestTransaction  = 4'b0000;
        begin_transactionIN = 1'b1;
        tick();
        begin_transactionIN = 1'b0;
        tick();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        check_value("t7_rst_grant", 32'(transactionGranted), 32'h0);
        check_value("t7_rst_owned", 32'(bus_owned), 32'h0);
        check_value("t7_rst_active", 32'(active_master), 32'h0);
        check_value("t7_rst_error", 32'(error_seen), 32'h0);
        check_value("t7_rst_no_force", 32'(end_transactionOUT), 32'h0);
        requestTransaction = 4'b1001;
        tick();
        check_value("t7_restart_m0", 32'(transactionGranted), 32'h1);
        requestTransaction = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single system bus between up to NUM_MASTERS bus masters (JTAG DMA engines, other bus masters) through a request/grant handshake.
- Round-robin fairness.
- Grant is held from bus grant through the whole transaction, until the bus-level end_transaction is seen.
- Watchdogs recover the bus from masters that never begin, or transactions that never end.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..8)
- BEGIN_TIMEOUT, 16, max cycles from grant to begin_transactionIN before the grant is revoked
- XFER_TIMEOUT, 1024, max cycles from begin_transactionIN to end_transactionIN before the arbiter forces end

Ports:
- clock  in  1  system clock
- n_reset  in  1  synchronous, active-low reset
- requestTransaction  in  NUM_MASTERS  per-master bus request, bit i = master i
- transactionGranted  out  NUM_MASTERS  one-hot grant, registered
- begin_transactionIN  in  1  bus-level begin_transaction (OR of all masters)
- end_transactionIN  in  1  bus-level end_transaction (master or slave driven)
- bus_errorIN  in  1  bus-level error
- end_transactionOUT  out  1  one-cycle forced end on transfer timeout
- bus_owned  out  1  high while in GRANT or BUSY
- active_master  out  3  index of current/last grantee
- begin_timeout  out  1  one-cycle pulse: grant revoked, no begin
- xfer_timeout  out  1  one-cycle pulse: transfer forced to end
- error_seen  out  1  sticky; set by bus_errorIN during BUSY, cleared only by reset

Behaviour:
- Reset (synchronous, n_reset=0 at clock edge):
  - state=IDLE, rr_pointer=0, counters=0.
  - All outputs 0; error_seen cleared.
  - Reset mid-transaction drops the grant at that edge; the arbiter does not issue end_transactionOUT.
- Picker (combinational):
  - Selects the first set request bit at index rr_pointer, rr_pointer+1, ..., wrapping modulo NUM_MASTERS.
  - Result is a valid flag and an index.
- FSM states: IDLE, GRANT, BUSY, RELEASE.
- IDLE:
  - If the picker is valid at edge t: transactionGranted[idx]=1 and active_master=idx from cycle t+1; state goes to GRANT; counter cleared.
  - Otherwise stay in IDLE.
- GRANT:
  - Grant is held. The master may drop its request here: a DMA drops its request one cycle after seeing the grant, then asserts begin one cycle later.
  - Dropping the request does NOT release the grant.
  - begin_transactionIN=1: go to BUSY, counter cleared.
  - Else if counter==BEGIN_TIMEOUT-1: pulse begin_timeout, go to RELEASE.
  - Else counter+1.
  - begin and timeout in the same cycle: begin wins, no pulse.
- BUSY:
  - Grant is held.
  - end_transactionIN=1: go to RELEASE.
  - Else if counter==XFER_TIMEOUT-1: drive end_transactionOUT=1 for exactly one cycle, pulse xfer_timeout, go to RELEASE.
  - end and timeout in the same cycle: end wins; no forced end, no pulse.
  - bus_errorIN sets error_seen but does not itself release; release waits for end_transactionIN or the timeout.
- RELEASE:
  - Grant deasserted (all zeros) for this cycle, giving one dead cycle between owners.
  - rr_pointer = (active_master+1) mod NUM_MASTERS.
  - Go to IDLE.
- Minimum handoff: grant falls in RELEASE; the next grant is high 2 cycles later (RELEASE, IDLE sample, grant).
- Counter width: clog2(max(BEGIN_TIMEOUT, XFER_TIMEOUT)). It never wraps; it is cleared on every state entry.
- Invariants:
  - transactionGranted is always zero or one-hot.
  - Grant is only ever given to a master whose request bit was set at grant time.
- A request bit arriving while another master is owner waits; no preemption.

Decomposition:
- Shared package: FSM state encodings (2-bit), NUM_MASTERS upper bound (8), active_master width constant.
- One sub-module, rr_picker: combinational round-robin selector (requests, pointer → valid, index).
- FSM, counters and output registers stay in bus_arbiter.

Test Plan:
- Single master 0 requests, begin 2 cycles after grant, end 10 cycles later → grant=0001 from cycle after request; bus_owned high until RELEASE; next grant possible 2 cycles after release; no pulses.
- Masters 0,1,2 request continuously, each transaction 5 cycles → grants in order 0,1,2,0,1,2; never two bits set; dead cycle between owners.
- Master 3 granted, never begins → begin_timeout pulse exactly 16 cycles after grant; grant dropped; rr_pointer=0; next requester served.
- Begin, then no end for 1024 cycles → end_transactionOUT and xfer_timeout high for one cycle; then RELEASE; error_seen stays 0.
- bus_errorIN pulse mid-transfer, end_transactionIN 3 cycles later → error_seen=1 (sticky); grant released on end only; same-cycle end + timeout → no forced end.
- n_reset asserted while BUSY → next edge: grants 0, bus_owned 0, active_master 0, error_seen 0; arbitration restarts from master 0.
